// File: rtl/rgmii_rx_frame_if.sv
// rgmii_rx_frame_if: demuxed RGMII receive inputs and frame-stream outputs with counters
interface rgmii_rx_frame_if;
  logic [7:0]  rx_data_mux;
  logic [1:0]  rx_ctl_mux;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_sof;
  logic        out_eof;
  logic        out_err;
  logic [15:0] frames_ok;
  logic [15:0] frames_bad;
  modport master (
    output rx_data_mux, rx_ctl_mux,
    input  out_data, out_valid, out_sof, out_eof, out_err, frames_ok, frames_bad
  );
  modport slave (
    input  rx_data_mux, rx_ctl_mux,
    output out_data, out_valid, out_sof, out_eof, out_err, frames_ok, frames_bad
  );
endinterface

// File: rtl/rgmii_rx_frame.sv
// rgmii_rx_frame: RGMII byte-stream frame receiver with preamble/SFD detect, FCS and length checks
module rgmii_rx_frame #(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1518
) (
  input logic             clk,
  input logic             reset,
  rgmii_rx_frame_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;
  state_t      r_state;
  logic [7:0]  r_hold;
  logic        r_have;
  logic        r_first;
  logic        r_err;
  logic [10:0] r_len;
  logic [31:0] r_crc;
  logic [31:0] w_crc_nx;
  logic [31:0] w_res;
  logic        w_dv;
  logic        w_er;
  logic        w_bad;
  logic [7:0]  w_d;
  assign w_d  = bus.rx_data_mux;
  assign w_dv = bus.rx_ctl_mux[0];
  assign w_er = bus.rx_ctl_mux[0] ^ bus.rx_ctl_mux[1];
  // reflected CRC-32, LSB first; the residue is compared in its bit-reversed form
  always_comb begin
    w_crc_nx = r_crc;
    w_res    = '0;
    for (int i = 0; i < 8; i++)
      w_crc_nx = (w_crc_nx >> 1) ^ ((w_crc_nx[0] ^ w_d[i]) ? 32'hEDB88320 : 32'h0);
    for (int i = 0; i < 32; i++)
      w_res[i] = r_crc[31-i];
  end
  assign w_bad = r_err | (w_res != 32'hC704DD7B) | ({21'b0, r_len} < MIN_LEN) | ({21'b0, r_len} > MAX_LEN);
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_hold         <= '0;
      r_have         <= 1'b0;
      r_first        <= 1'b0;
      r_err          <= 1'b0;
      r_len          <= '0;
      r_crc          <= 32'hFFFFFFFF;
      bus.out_data   <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_sof    <= 1'b0;
      bus.out_eof    <= 1'b0;
      bus.out_err    <= 1'b0;
      bus.frames_ok  <= '0;
      bus.frames_bad <= '0;
    end else begin
      bus.out_valid <= 1'b0;
      bus.out_sof   <= 1'b0;
      bus.out_eof   <= 1'b0;
      bus.out_err   <= 1'b0;
      case (r_state)
        IDLE: if (w_dv) r_state <= (!w_er && w_d == 8'h55) ? PREAMBLE : DROP;
        PREAMBLE: begin
          if (!w_dv) r_state <= IDLE;
          else if (w_er) r_state <= DROP;
          else if (w_d == 8'hD5) begin
            r_state <= DATA;
            r_len   <= '0;
            r_crc   <= 32'hFFFFFFFF;
            r_err   <= 1'b0;
            r_have  <= 1'b0;
          end else if (w_d != 8'h55) r_state <= DROP;
        end
        DATA: begin
          if (w_dv) begin
            r_hold  <= w_d;
            r_have  <= 1'b1;
            r_first <= !r_have;
            r_len   <= (r_len == 11'h7FF) ? r_len : r_len + 11'd1;
            r_crc   <= w_crc_nx;
            if (w_er) r_err <= 1'b1;
            if (r_have) begin
              bus.out_valid <= 1'b1;
              bus.out_data  <= r_hold;
              bus.out_sof   <= r_first;
            end
          end else begin
            r_state <= IDLE;
            r_have  <= 1'b0;
            if (r_have) begin
              bus.out_valid <= 1'b1;
              bus.out_data  <= r_hold;
              bus.out_sof   <= r_first;
              bus.out_eof   <= 1'b1;
              bus.out_err   <= w_bad;
            end
            if (w_bad || !r_have) bus.frames_bad <= bus.frames_bad + 16'd1;
            else bus.frames_ok <= bus.frames_ok + 16'd1;
          end
        end
        DROP: if (!w_dv) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rgmii_rx_frame.sv
// tb_rgmii_rx_frame: directed and randomized frames checked against a frame-level reference model
module tb_rgmii_rx_frame;
  typedef logic [7:0] bq_t[$];
  typedef struct packed {logic [7:0] d; logic s; logic e; logic r; logic [31:0] c;} ent_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_vec = 0, n_bad = 0, cyc = 0, idle_viol = 0;
  int exp_ok = 0, exp_bad = 0;
  ent_t mq[$];
  rgmii_rx_frame_if bus();
  rgmii_rx_frame #(.MIN_LEN(64), .MAX_LEN(1518)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #4 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) mq.push_back({bus.out_data, bus.out_sof, bus.out_eof, bus.out_err, cyc});
    else if (bus.out_sof === 1'b1 || bus.out_eof === 1'b1 || bus.out_err === 1'b1) idle_viol++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] crc32(bq_t q, int n);
    logic [31:0] c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c ^= {24'b0, q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction
  function automatic bq_t mkframe(int n, bit good);
    bq_t q;
    logic [31:0] f;
    for (int i = 0; i < n - 4; i++) q.push_back(8'($urandom));
    f = crc32(q, n - 4);
    q.push_back(f[7:0]); q.push_back(f[15:8]); q.push_back(f[23:16]); q.push_back(f[31:24]);
    if (!good) q[n-1] ^= 8'h01;
    return q;
  endfunction
  function automatic bit model_err(bq_t q, int er_idx);
    int n = q.size();
    bit fcs_ok = (n >= 4) && ({q[n-1], q[n-2], q[n-3], q[n-4]} == crc32(q, n - 4));
    return (er_idx >= 0) || !fcs_ok || n < 64 || n > 1518;
  endfunction
  task automatic drive(input logic [7:0] d, input bit dv, input bit er);
    @(negedge clk);
    bus.rx_data_mux = d;
    bus.rx_ctl_mux  = {dv ^ er, dv};
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(8'($urandom), 1'b0, 1'($urandom));
  endtask
  task automatic preamble();
    for (int i = 0; i < 7; i++) drive(8'h55, 1'b1, 1'b0);
  endtask
  task automatic send_frame(input bq_t q, input int er_idx, input int gap, output int start);
    preamble();
    drive(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < q.size(); i++) begin
      drive(q[i], 1'b1, i == er_idx);
      if (i == 0) start = cyc;
    end
    idle(gap);
  endtask
  task automatic settle();
    idle(3);
    #1;
  endtask
  task automatic check_frame(input bq_t q, input int er_idx, input int start, input string tag);
    int n = q.size(), m, dm = 0, fm = 0;
    logic [31:0] fc = 0, lc = 0;
    logic le = 1'bx;
    bit e = model_err(q, er_idx);
    ent_t x;
    chk({tag, ".avail"}, 32'(mq.size() >= n), 1);
    m = (mq.size() < n) ? mq.size() : n;
    for (int i = 0; i < m; i++) begin
      x = mq.pop_front();
      if (x.d !== q[i]) dm++;
      if (x.s !== (i == 0)) fm++;
      if (x.e !== (i == n - 1)) fm++;
      if (i == 0) fc = x.c;
      if (i == m - 1) begin lc = x.c; le = x.r; end
    end
    chk({tag, ".data"}, dm, 0);
    chk({tag, ".flags"}, fm, 0);
    chk({tag, ".err"}, {31'b0, le}, {31'b0, e});
    chk({tag, ".first_cyc"}, fc, start + 2);
    chk({tag, ".last_cyc"}, lc, start + 1 + n);
    if (e) exp_bad++; else exp_ok++;
  endtask
  task automatic chk_cnt(input string tag);
    chk({tag, ".left"}, mq.size(), 0);
    chk({tag, ".ok"}, bus.frames_ok, 16'(exp_ok));
    chk({tag, ".bad"}, bus.frames_bad, 16'(exp_bad));
    mq.delete();
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.rx_data_mux = 8'h00;
    bus.rx_ctl_mux  = 2'b00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_ok = 0;
    exp_bad = 0;
    #1;
    mq.delete();
  endtask
  initial begin
    bq_t q, q2, fr[6];
    int st, st2, sts[6], ers[6], eofs;
    bus.rx_data_mux = 8'h00;
    bus.rx_ctl_mux  = 2'b00;
    do_reset();
    chk("rst.valid", bus.out_valid, 0);
    chk("rst.data", bus.out_data, 0);
    chk("rst.sof", bus.out_sof, 0);
    chk("rst.eof", bus.out_eof, 0);
    chk("rst.err", bus.out_err, 0);
    chk_cnt("rst");
    q = mkframe(64, 1); send_frame(q, -1, 3, st); settle(); check_frame(q, -1, st, "good64"); chk_cnt("good64");
    q = mkframe(64, 0); send_frame(q, -1, 3, st); settle(); check_frame(q, -1, st, "badfcs"); chk_cnt("badfcs");
    q = mkframe(40, 1); send_frame(q, -1, 3, st); settle(); check_frame(q, -1, st, "runt"); chk_cnt("runt");
    q = mkframe(1519, 1); send_frame(q, -1, 3, st); settle(); check_frame(q, -1, st, "len1519"); chk_cnt("len1519");
    q = mkframe(1518, 1); send_frame(q, -1, 3, st); settle(); check_frame(q, -1, st, "len1518"); chk_cnt("len1518");
    q = mkframe(2112, 1); send_frame(q, -1, 3, st); settle(); check_frame(q, -1, st, "len2112"); chk_cnt("len2112");
    q = mkframe(64, 1); send_frame(q, 10, 3, st); settle(); check_frame(q, 10, st, "er10"); chk_cnt("er10");
    preamble();
    drive(8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) drive(8'($urandom), 1'b1, 1'b0);
    settle(); chk_cnt("badsfd");
    preamble(); drive(8'hD5, 1'b1, 1'b0); settle();
    exp_bad++;
    chk_cnt("empty");
    for (int k = 0; k < 6; k++) begin
      fr[k] = mkframe($urandom_range(60, 80), 1'($urandom));
      ers[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 50) : -1;
      send_frame(fr[k], ers[k], $urandom_range(1, 3), sts[k]);
    end
    settle();
    for (int k = 0; k < 6; k++) check_frame(fr[k], ers[k], sts[k], $sformatf("rnd%0d", k));
    chk_cnt("rnd");
    q = mkframe(64, 1); q[31] = 8'h11;
    preamble(); drive(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < 30; i++) drive(q[i], 1'b1, 1'b0);
    for (int i = 30; i < 64; i++) begin
      drive(q[i], 1'b1, 1'b0);
      reset = (i == 30);
    end
    idle(3);
    settle();
    exp_ok = 0;
    exp_bad = 0;
    chk("rstmid.bytes", mq.size(), 29);
    eofs = 0;
    foreach (mq[i]) if (mq[i].e) eofs++;
    chk("rstmid.eof", eofs, 0);
    mq.delete();
    chk_cnt("rstmid");
    q = mkframe(64, 1); send_frame(q, -1, 3, st); settle(); check_frame(q, -1, st, "after_rst"); chk_cnt("after_rst");
    do_reset();
    q = mkframe(64, 1); q2 = mkframe(70, 1);
    send_frame(q, -1, 1, st); send_frame(q2, -1, 3, st2); settle();
    check_frame(q, -1, st, "b2b0"); check_frame(q2, -1, st2, "b2b1"); chk_cnt("b2b");
    chk("idle_flags", idle_viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/rgmii_rx_frame.md
RGMII_RX_FRAME -- requirements
Module: rgmii_rx_frame

Interface
REQ-001 Parameter MIN_LEN, default 64: minimum legal frame length in bytes (SFD excluded, FCS included).
REQ-002 Parameter MAX_LEN, default 1518: maximum legal frame length in bytes, counted the same way.
REQ-003 clk  input  1  125 MHz RX clock (BUFG'd phy_rx_clk); one clock domain, all logic on posedge clk.
REQ-004 reset  input  1  reset, synchronous and active-high.
REQ-005 rx_data_mux  input  8  demuxed RGMII byte from the IDDR2 stage; [3:0] = rising-edge nibble (low), [7:4] = falling-edge nibble (high).
REQ-006 rx_ctl_mux  input  2  [0] = RX_DV (rising edge); [1] = RX_DV xor RX_ER (falling edge).
REQ-007 out_data  output  8  received frame byte.
REQ-008 out_valid  output  1  out_data valid this cycle; no backpressure.
REQ-009 out_sof  output  1  first byte after SFD; qualified by out_valid.
REQ-010 out_eof  output  1  last byte of frame (last FCS byte); qualified by out_valid.
REQ-011 out_err  output  1  frame status; meaningful only with out_valid & out_eof; 1 = bad frame.
REQ-012 frames_ok  output  16  count of frames ended with out_err=0; wraps at 65535->0.
REQ-013 frames_bad  output  16  count of frames ended with out_err=1; wraps at 65535->0.

Function
REQ-014 dv = rx_ctl_mux[0]; er = rx_ctl_mux[0] ^ rx_ctl_mux[1]; a sample is one posedge with its rx_data_mux/dv/er.
REQ-015 FSM states IDLE, PREAMBLE, DATA, DROP.
REQ-016 IDLE: dv=1 & er=0 & byte=0x55 -> PREAMBLE; any other dv=1 sample -> DROP; dv=0 -> stay.
REQ-017 PREAMBLE: dv=0 -> IDLE; er=1 -> DROP; byte 0x55 -> stay; byte 0xD5 -> DATA (clear length, CRC=0xFFFFFFFF, clear error flag); other byte -> DROP.
REQ-018 DROP: ignore samples with dv=1; dv=0 -> IDLE; no output, no counter change.
REQ-019 DATA, dv=1: byte accepted, length += 1 (11-bit, saturating at 2047), CRC-32 (poly 0x04C11DB7, reflected, LSB first) updated, er=1 sets sticky error flag (byte still accepted).
REQ-020 DATA, dv=0: end of frame -> IDLE; the dv=0 sample is not a byte.
REQ-021 Each accepted byte is held one stage; it is driven on out_data with out_valid=1 registered at the next posedge (fixed latency: sample edge k -> output after edge k+1).
REQ-022 out_sof=1 on the first byte emitted after SFD; out_eof=1 on the byte emitted at the end-of-frame edge.
REQ-023 out_err at eof = sticky error | (CRC residue != 0xC704DD7B) | (length < MIN_LEN) | (length > MAX_LEN).
REQ-024 Counters update at the same edge as out_eof: frames_ok+1 if out_err=0, else frames_bad+1.
REQ-025 SFD followed immediately by dv=0 (zero bytes): no out_valid; frames_bad+1.
REQ-026 Back-to-back frames with a single dv=0 cycle between them are both received; outputs of frame N complete before sof of frame N+1.
REQ-027 out_valid, out_sof, out_eof, out_err are 0 in every cycle without a valid byte.
REQ-028 dv=0 with er=1 (carrier extension / false carrier) is treated as dv=0.

Reset
REQ-029 On reset: state IDLE; out_data=0, out_valid=0, out_sof=0, out_eof=0, out_err=0; frames_ok=0, frames_bad=0; length=0, CRC=0xFFFFFFFF, held byte cleared.
REQ-030 Reset mid-frame abandons the frame: no eof, no counter change; if dv is still 1 after reset, the frame goes through IDLE -> DROP.

Verification
REQ-031 7x0x55, 0xD5, 60 payload bytes, correct FCS -> 64 out_valid cycles, sof on byte 1, eof on byte 64 with out_err=0, frames_ok=1.
REQ-032 Same frame with last FCS byte XOR 0x01 -> eof with out_err=1, frames_bad=1, frames_ok=0.
REQ-033 40-byte frame with valid FCS -> out_err=1 (runt); 1519-byte frame -> out_err=1; 1518-byte frame -> out_err=0.
REQ-034 er=1 for one cycle on payload byte 10 of a 64-byte good frame -> 64 bytes delivered, out_err=1.
REQ-035 Preamble then 0x00 instead of 0xD5, dv held 20 cycles -> no out_valid, both counters unchanged.
REQ-036 Reset asserted on payload byte 30, dv stays high -> no eof; next good frame after dv=0 -> frames_ok=1. Two good frames with a 1-cycle gap -> frames_ok=2.
